johnson_counter_param: RTL
==========================

Name: johnson_counter_param

Overview:
Parametrised successor to the fixed 4-bit Johnson counter. Generates a WIDTH-bit Johnson (twisted-ring) or plain ring sequence with these controls:
- enable, direction and parallel load,
- illegal-load recovery,
- phase index and wrap pulse outputs.
Used as a phase/sequence generator and as the unit under test for the lab test bench, driven by a tester module.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..16.
PW, $clog2(2*WIDTH), width of the phase output (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low
en  input  1  step enable; one step per clock while high
dir  input  1  0 = forward, 1 = reverse
mode  input  1  0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states)
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
out  output  WIDTH  counter state (registered)
phase  output  PW  index of out within the current sequence (registered)
wrap  output  1  one-cycle pulse marking sequence wrap (registered)
err  output  1  one-cycle pulse on illegal load (registered)

Behaviour:
- All outputs are registered and update on the rising clk edge. There is no combinational path from inputs to outputs.
- Reset (rst=0 at a clk edge): out=0, phase=0, wrap=0, err=0, internal mode_q=0. Reset overrides everything, including mid-sequence.
- Priority per edge: reset > mode change > load > en step > hold.
- Initial value: INIT(0) = all zeros; INIT(1) = {0..0,1}.
- Mode change (mode != mode_q): mode_q<=mode, out<=INIT(mode), phase<=0, wrap=0, err=0. Takes effect regardless of en; load and step are ignored that cycle.
- Johnson forward: out <= {out[WIDTH-2:0], ~out[WIDTH-1]}.
- Johnson reverse: out <= {~out[0], out[WIDTH-1:1]}.
- Ring forward: out <= {out[WIDTH-2:0], out[WIDTH-1]}.
- Ring reverse: out <= {out[0], out[WIDTH-1:1]}.
- Phase: LAST = 2*WIDTH-1 (Johnson) or WIDTH-1 (ring).
  - Forward step: phase+1, with LAST -> 0.
  - Reverse step: phase-1, with 0 -> LAST.
- wrap: 1 for exactly the cycle in which out first shows a wrapped state:
  - phase 0 reached from LAST while going forward, or
  - LAST reached from 0 while going reverse.
  - Otherwise 0. Holding (en=0) never asserts wrap.
- Load (independent of en):
  - Legal Johnson values are the 2*WIDTH Johnson patterns. Legal ring values are exactly one-hot.
  - Legal value: out<=load_val.
    - Johnson phase: popcount(load_val) if msb=0, else 2*WIDTH - popcount.
    - Ring phase: bit position of the single 1.
    - err=0, wrap=0.
  - Illegal value: out<=INIT(mode_q), phase<=0, err=1 for one cycle, wrap=0.
- Invariant: out is always a legal state for mode_q, and phase always matches out.
- dir may change on any cycle; the next step uses the new direction with no bubble.
- Single-cycle latency: inputs sampled at edge N are visible on outputs after edge N.

Test Plan:
1. Reset: WIDTH=4, hold rst=0 for 2 cycles with en=1, mode=0 -> out=0000, phase=0, wrap=0, err=0. Assert rst=0 again mid-count (out=0111) -> out=0000 next edge.
2. Johnson forward: en=1, dir=0 for 9 edges -> out = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; phase = 1..7, 0, 1; wrap=1 only on the 8th edge (out=0000).
3. Reverse and hold: from 0000, dir=1 -> out=1000, phase=7, wrap=1; next edge 1100, phase=6, wrap=0. en=0 for 3 edges -> out stays 1100, wrap=0.
4. Load: load=1, load_val=1110 -> out=1110, phase=5, err=0. load_val=0101 -> out=0000, phase=0, err=1 for one cycle. load with en=0 still loads.
5. Mode switch: mode=1 -> next edge out=0001, phase=0 even with en=0. With en=1, dir=0 -> 0010, 0100, 1000, 0001; wrap on 0001. load_val=0011 -> out=0001, err=1.
6. Priority: mode change, load and en all asserted on the same edge -> mode change wins (out=INIT). Reset while mode=1 held -> out=0000, then next edge out=0001.

Source files
------------

// File: rtl/johnson_counter_param.sv
// -----------------------------------------------------------------------------
// johnson_counter_param
//
// WIDTH-bit sequence generator producing either a Johnson (twisted-ring)
// sequence of 2*WIDTH states or a plain one-hot ring sequence of WIDTH
// states. Supports step enable, direction, parallel load with recovery from
// illegal load values, and reports the phase index of the current state plus
// a one-cycle wrap pulse. All outputs are registered.
//
// WIDTH is legal in the range 2..16. PW is derived and must not be overridden.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   en        step enable, one step per clock while high
//   dir       0 = forward, 1 = reverse
//   mode      0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states)
//   load      parallel load strobe (independent of en)
//   load_val  value to load
//   out       counter state
//   phase     index of out within the current sequence
//   wrap      one-cycle pulse when the sequence wraps
//   err       one-cycle pulse when an illegal value was loaded
// -----------------------------------------------------------------------------
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    // Starting state of each sequence: all zeros for Johnson, bit 0 for ring.
    function automatic logic [WIDTH-1:0] init_val(input logic m);
        return m ? WIDTH'(1) : '0;
    endfunction

    function automatic int popcount(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    // A Johnson pattern is a run of ones anchored at bit 0 (msb clear) or a
    // run of ones anchored at the msb (msb set). A value of the form 2^k-1
    // has no bits in common with its increment.
    function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] t_inc;
        t     = v[WIDTH-1] ? ~v : v;
        t_inc = t + WIDTH'(1);
        return (t & t_inc) == '0;
    endfunction

    function automatic logic ring_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] v_dec;
        v_dec = v - WIDTH'(1);
        return (v != '0) && ((v & v_dec) == '0);
    endfunction

    function automatic logic [PW-1:0] johnson_phase(input logic [WIDTH-1:0] v);
        int p;
        p = v[WIDTH-1] ? (2 * WIDTH - popcount(v)) : popcount(v);
        return PW'(p);
    endfunction

    function automatic logic [PW-1:0] ring_phase(input logic [WIDTH-1:0] v);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) p = PW'(i);
        end
        return p;
    endfunction

    logic             mode_q;
    logic             mode_d;
    logic [WIDTH-1:0] out_d;
    logic [PW-1:0]    phase_d;
    logic             wrap_d;
    logic             err_d;
    logic [PW-1:0]    last;

    assign last = mode_q ? PW'(WIDTH - 1) : PW'(2 * WIDTH - 1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        mode_d  = mode_q;
        out_d   = out;
        phase_d = phase;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        if (mode != mode_q) begin
            // Mode switch restarts the new sequence; load and step are ignored.
            mode_d  = mode;
            out_d   = init_val(mode);
            phase_d = '0;
        end else if (load) begin
            if (mode_q ? ring_legal(load_val) : johnson_legal(load_val)) begin
                out_d   = load_val;
                phase_d = mode_q ? ring_phase(load_val) : johnson_phase(load_val);
            end else begin
                // Never let an illegal pattern into the state register.
                out_d   = init_val(mode_q);
                phase_d = '0;
                err_d   = 1'b1;
            end
        end else if (en) begin
            if (!dir) begin
                out_d   = mode_q ? {out[WIDTH-2:0], out[WIDTH-1]}
                                 : {out[WIDTH-2:0], ~out[WIDTH-1]};
                phase_d = (phase == last) ? '0 : phase + PW'(1);
                wrap_d  = (phase == last);
            end else begin
                out_d   = mode_q ? {out[0], out[WIDTH-1:1]}
                                 : {~out[0], out[WIDTH-1:1]};
                phase_d = (phase == '0) ? last : phase - PW'(1);
                wrap_d  = (phase == '0);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= 1'b0;
            out    <= '0;
            phase  <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            mode_q <= mode_d;
            out    <= out_d;
            phase  <= phase_d;
            wrap   <= wrap_d;
            err    <= err_d;
        end
    end

endmodule
